// File: rtl/nibble_adder_pkg.sv
// Shared definitions for the nibble-serial adder: state encoding, nibble width
// and the nibble-index width helper.
package nibble_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // A single-nibble operand still needs a 1-bit index register.
  function automatic int idxWidth(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/binary_adder.sv
// 4-bit combinational binary adder with carry-in and carry-out; the shared
// datapath of the nibble-serial adder.
module binary_adder
  import nibble_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic                c_i,
  output logic [NIBBLE_W-1:0] sum_o,
  output logic                c_o
);

  assign {c_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{NIBBLE_W{1'b0}}, c_i};

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that reuses one 4-bit binary_adder, one nibble per clock,
// LSB first. Define OVERFLOW_FLAG_EN to add the signed-overflow output ovf.
module nibble_serial_adder
  import nibble_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IW      = idxWidth(NIBBLES);

  state_e state_q, state_d;

  logic [WIDTH-1:0]    opA_q, opA_d;
  logic [WIDTH-1:0]    opB_q, opB_d;
  logic [WIDTH-1:0]    work_q, work_d;
  logic [WIDTH-1:0]    sum_q, sum_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                carry_q, carry_d;
  logic                cout_q, cout_d;
`ifdef OVERFLOW_FLAG_EN
  logic                ovf_q, ovf_d;
`endif

  logic [NIBBLE_W-1:0] nibA, nibB, nibSum;
  logic                nibCarry;
  logic                lastNibble;

  assign nibA       = opA_q[NIBBLE_W*int'(idx_q) +: NIBBLE_W];
  assign nibB       = opB_q[NIBBLE_W*int'(idx_q) +: NIBBLE_W];
  assign lastNibble = (idx_q == IW'(NIBBLES - 1));

  binary_adder u_adder (
    .a_i  (nibA),
    .b_i  (nibB),
    .c_i  (carry_q),
    .sum_o(nibSum),
    .c_o  (nibCarry)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (lastNibble) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  // Operands are frozen at acceptance so input changes during RUN are harmless.
  always_comb begin
    opA_d   = opA_q;
    opB_d   = opB_q;
    work_d  = work_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef OVERFLOW_FLAG_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          opA_d   = A;
          opB_d   = B;
          carry_d = c_in;
          idx_d   = '0;
          work_d  = '0;
        end
      end
      RUN: begin
        work_d[NIBBLE_W*int'(idx_q) +: NIBBLE_W] = nibSum;
        carry_d = nibCarry;
        idx_d   = idx_q + IW'(1);
        if (lastNibble) begin
          sum_d  = work_d;
          cout_d = nibCarry;
`ifdef OVERFLOW_FLAG_EN
          ovf_d  = (opA_q[WIDTH-1] == opB_q[WIDTH-1]) &&
                   (work_d[WIDTH-1] != opA_q[WIDTH-1]);
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opA_q   <= '0;
      opB_q   <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef OVERFLOW_FLAG_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign sum   = sum_q;
  assign c_out = cout_q;
`ifdef OVERFLOW_FLAG_EN
  assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder at WIDTH=16; the ovf
// checks are compiled in when OVERFLOW_FLAG_EN is defined.
module tb_nibble_serial_adder;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] A, B;
  logic             c_in;
  logic             busy, done, c_out;
  logic [WIDTH-1:0] sum;
`ifdef OVERFLOW_FLAG_EN
  logic             ovf;
`endif

  int checks = 0;
  int errors = 0;
  int doneCount = 0;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .c_in (c_in),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .c_out(c_out)
`ifdef OVERFLOW_FLAG_EN
    ,
    .ovf  (ovf)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) doneCount++;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives inputs just after a falling edge so the next rising edge samples them.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic cin);
    @(negedge clk);
    A = a; B = b; c_in = cin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = ~a; B = ~b; c_in = ~cin;
  endtask

  // Launches one addition and checks latency, busy, sum hold, result and done width.
  task automatic runOp(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin, input logic [WIDTH-1:0] expSum, input logic expCout,
                       input logic expOvf, input logic [WIDTH-1:0] prevSum);
    int n;
    int d0;
    d0 = doneCount;
    applyStimulus(a, b, cin);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      checkOutput({tag, "_busy_run"}, 32'(busy), 32'd1);
      checkOutput({tag, "_sum_hold"}, 32'(sum), 32'(prevSum));
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_latency"}, 32'(n), 32'd4);
    checkOutput({tag, "_busy_done"}, 32'(busy), 32'd1);
    checkOutput({tag, "_sum"}, 32'(sum), 32'(expSum));
    checkOutput({tag, "_cout"}, 32'(c_out), 32'(expCout));
`ifdef OVERFLOW_FLAG_EN
    checkOutput({tag, "_ovf"}, 32'(ovf), 32'(expOvf));
`else
    if (expOvf) $display("[TB] note: %s expects overflow, flag not built", tag);
`endif
    @(negedge clk);
    checkOutput({tag, "_done_low"}, 32'(done), 32'd0);
    checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done_count"}, 32'(doneCount - d0), 32'd1);
  endtask

  initial begin
    int d0;
    rst = 1'b1; start = 1'b0; A = '0; B = '0; c_in = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_sum", 32'(sum), 32'd0);
    checkOutput("reset_cout", 32'(c_out), 32'd0);
`ifdef OVERFLOW_FLAG_EN
    checkOutput("reset_ovf", 32'(ovf), 32'd0);
`endif
    rst = 1'b0;

    runOp("small",  16'h0002, 16'h0003, 1'b0, 16'h0005, 1'b0, 1'b0, 16'h0000);
    runOp("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0005);
    runOp("cin",    16'h000F, 16'h0004, 1'b1, 16'h0014, 1'b0, 1'b0, 16'h0000);

    // A second start during RUN must be dropped without queuing.
    d0 = doneCount;
    applyStimulus(16'h0010, 16'h0020, 1'b0);
    start = 1'b1; A = 16'hFFFF; B = 16'hFFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("ignore_sum", 32'(sum), 32'h0030);
    checkOutput("ignore_cout", 32'(c_out), 32'd0);
    checkOutput("ignore_busy", 32'(busy), 32'd0);
    checkOutput("ignore_done_count", 32'(doneCount - d0), 32'd1);

    // Reset on the second RUN edge aborts the operation.
    d0 = doneCount;
    applyStimulus(16'h1234, 16'h1111, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_sum", 32'(sum), 32'd0);
    checkOutput("abort_cout", 32'(c_out), 32'd0);
    repeat (6) @(negedge clk);
    checkOutput("abort_no_done", 32'(doneCount - d0), 32'd0);
    runOp("after_abort", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 16'h0000);

`ifdef OVERFLOW_FLAG_EN
    runOp("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 16'h2345);
    runOp("ovf_neg", 16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1, 16'h8000);
    runOp("ovf_none", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 16'h7FFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
